neuron_sequencer: RTL and testbench

Control and streaming stage that sits directly upstream of the neuron multiply-accumulate block. It computes one dot product per command: it reads an input vector and one weight row from synchronous-read memories, clears the neuron, streams Q16.16 operand pairs into it, then adds a bias, optionally applies ReLU, and presents the result. One instance drives one neuron.

---
 rtl/neuron_sequencer_if.sv | 34 +++
 rtl/neuron_sequencer.sv | 91 +++++++++
 tb/tb_neuron_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/neuron_sequencer_if.sv
// Command, memory-read and neuron-operand signals between a neuron_sequencer
// and its surroundings; the slave modport is the sequencer's view.
interface neuron_sequencer_if #(parameter int ADDR_W = 10);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] num_inputs;
  logic [31:0]       bias;
  logic              relu_en;
  logic [ADDR_W-1:0] data_addr;
  logic [ADDR_W-1:0] w_addr;
  logic              mem_rd;
  logic [31:0]       mem_data;
  logic [31:0]       mem_weight;
  logic              n_clear;
  logic              n_en;
  logic [31:0]       n_data;
  logic [31:0]       n_weight;
  logic [31:0]       n_accum;
  logic [31:0]       result;
  logic              result_valid;
  logic              busy;

  modport master (
    output start, base_addr, num_inputs, bias, relu_en, mem_data, mem_weight, n_accum,
    input  data_addr, w_addr, mem_rd, n_clear, n_en, n_data, n_weight,
           result, result_valid, busy
  );

  modport slave (
    input  start, base_addr, num_inputs, bias, relu_en, mem_data, mem_weight, n_accum,
    output data_addr, w_addr, mem_rd, n_clear, n_en, n_data, n_weight,
           result, result_valid, busy
  );
endinterface

// File: rtl/neuron_sequencer.sv
// Streams one input vector and one weight row into a neuron MAC, then adds the
// bias and optionally applies ReLU to produce one Q16.16 result per command.
//
// state | meaning
// IDLE  | waiting for start, last result held
// CLEAR | neuron cleared, read of element 0 issued when N>0
// FEED  | read element i issued, pair i-1 presented
// LAST  | final pair presented, no read
// SUM   | neuron holds full sum, result registered
module neuron_sequencer #(
  parameter int ADDR_W = 10
) (
  input logic clk,
  input logic rst,
  neuron_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, LAST, SUM} state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] num_q;
  logic [31:0]       bias_q;
  logic              relu_q;
  logic [31:0]       biased;

  assign biased = bus.n_accum + bias_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      idx              <= '0;
      base_q           <= '0;
      num_q            <= '0;
      bias_q           <= '0;
      relu_q           <= 1'b0;
      bus.result       <= '0;
      bus.result_valid <= 1'b0;
    end else begin
      bus.result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            base_q <= bus.base_addr;
            num_q  <= bus.num_inputs;
            bias_q <= bus.bias;
            relu_q <= bus.relu_en;
            idx    <= '0;
            state  <= CLEAR;
          end
        end
        CLEAR: begin
          idx <= ADDR_W'(1);
          if (num_q == '0)
            state <= SUM;
          else if (num_q == ADDR_W'(1))
            state <= LAST;
          else
            state <= FEED;
        end
        FEED: begin
          idx <= idx + ADDR_W'(1);
          if (idx == num_q - ADDR_W'(1))
            state <= LAST;
        end
        LAST: state <= SUM;
        SUM: begin
          bus.result       <= (relu_q && biased[31]) ? 32'h0 : biased;
          bus.result_valid <= 1'b1;
          idx              <= '0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operands are zeroed outside n_en because the neuron accumulates every non-clear cycle.
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.n_clear   = (state == CLEAR);
    bus.n_en      = (state == FEED) || (state == LAST);
    bus.mem_rd    = ((state == CLEAR) && (num_q != '0)) || (state == FEED);
    bus.data_addr = bus.mem_rd ? idx : '0;
    bus.w_addr    = bus.mem_rd ? (base_q + idx) : '0;
    bus.n_data    = bus.n_en ? bus.mem_data : 32'h0;
    bus.n_weight  = bus.n_en ? bus.mem_weight : 32'h0;
  end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed bench for neuron_sequencer with behavioural memories and a Q16.16
// neuron accumulator model.
module tb_neuron_sequencer;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   gate_err = 0;

  logic [31:0] dmem [1024];
  logic [31:0] wmem [1024];
  logic [9:0]  wa_log [16];
  logic [9:0]  da_log [16];
  int          nlog;

  neuron_sequencer_if #(.ADDR_W(10)) bus ();

  neuron_sequencer #(.ADDR_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed(a) * $signed(b);
    return p[47:16];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      bus.mem_data   <= 32'h0;
      bus.mem_weight <= 32'h0;
    end else if (bus.mem_rd) begin
      bus.mem_data   <= dmem[bus.data_addr];
      bus.mem_weight <= wmem[bus.w_addr];
    end
  end

  always @(posedge clk) begin
    if (rst || bus.n_clear)
      bus.n_accum <= 32'h0;
    else
      bus.n_accum <= bus.n_accum + qmul(bus.n_data, bus.n_weight);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one command at the current negedge and returns at the negedge where result_valid is seen.
  task automatic run_cmd(input logic [9:0] base, input logic [9:0] n, input logic [31:0] b,
                         input logic relu, input bit repulse, output int lat,
                         output int en_cnt, output int rd_cnt, output logic [31:0] res);
    lat = -1; en_cnt = 0; rd_cnt = 0; nlog = 0;
    bus.start      = 1'b1;
    bus.base_addr  = base;
    bus.num_inputs = n;
    bus.bias       = b;
    bus.relu_en    = relu;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (bus.n_en) en_cnt++;
      else if (bus.n_data != 32'h0 || bus.n_weight != 32'h0) gate_err++;
      if (bus.mem_rd) begin
        rd_cnt++;
        if (nlog < 16) begin
          wa_log[nlog] = bus.w_addr;
          da_log[nlog] = bus.data_addr;
          nlog++;
        end
      end
      bus.start = repulse && bus.busy;
      if (repulse) begin
        bus.bias      = 32'h7FFF0000;
        bus.relu_en   = ~relu;
        bus.num_inputs = 10'd1;
      end
      if (bus.result_valid) begin
        lat = k;
        break;
      end
    end
    bus.start = 1'b0;
    res = bus.result;
  endtask

  int          lat, en_cnt, rd_cnt, rv_cnt;
  logic [31:0] res;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dmem[i] = 32'h00010000;
      wmem[i] = 32'h00000000;
    end
    bus.start = 1'b0; bus.base_addr = '0; bus.num_inputs = '0; bus.bias = '0; bus.relu_en = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_result", bus.result, 32'h0);
    check("rst_valid", 32'(bus.result_valid), 32'h0);
    check("rst_ctrl", {29'h0, bus.mem_rd, bus.n_clear, bus.n_en}, 32'h0);
    check("rst_addr", {12'h0, bus.data_addr, bus.w_addr}, 32'h0);
    check("rst_ops", bus.n_data | bus.n_weight, 32'h0);

    // N=4: 4 x (1.0*2.0) + 0.5 = 8.5
    for (int i = 10; i < 14; i++) wmem[i] = 32'h00020000;
    run_cmd(10'd10, 10'd4, 32'h00008000, 1'b0, 1'b0, lat, en_cnt, rd_cnt, res);
    check("n4_result", res, 32'h00088000);
    check("n4_latency", 32'(lat), 32'd7);
    check("n4_en_cycles", 32'(en_cnt), 32'd4);
    check("n4_rd_cycles", 32'(rd_cnt), 32'd4);

    repeat (2) @(negedge clk);
    run_cmd(10'd10, 10'd0, 32'hFFFF0000, 1'b0, 1'b0, lat, en_cnt, rd_cnt, res);
    check("n0_result", res, 32'hFFFF0000);
    check("n0_latency", 32'(lat), 32'd3);
    check("n0_rd_cycles", 32'(rd_cnt), 32'd0);
    check("n0_en_cycles", 32'(en_cnt), 32'd0);
    run_cmd(10'd10, 10'd0, 32'hFFFF0000, 1'b1, 1'b0, lat, en_cnt, rd_cnt, res);
    check("n0_relu_result", res, 32'h0);

    // N=2: 2 x (1.0 * -2.0) = -4.0
    wmem[100] = 32'hFFFE0000; wmem[101] = 32'hFFFE0000;
    repeat (1) @(negedge clk);
    run_cmd(10'd100, 10'd2, 32'h0, 1'b1, 1'b0, lat, en_cnt, rd_cnt, res);
    check("n2_relu_result", res, 32'h0);
    check("n2_latency", 32'(lat), 32'd5);
    run_cmd(10'd100, 10'd2, 32'h0, 1'b0, 1'b0, lat, en_cnt, rd_cnt, res);
    check("n2_result", res, 32'hFFFC0000);

    // N=3 with start held every busy cycle: 1+2+3 = 6.0
    wmem[200] = 32'h00010000; wmem[201] = 32'h00020000; wmem[202] = 32'h00030000;
    repeat (2) @(negedge clk);
    run_cmd(10'd200, 10'd3, 32'h0, 1'b0, 1'b1, lat, en_cnt, rd_cnt, res);
    check("repulse_result", res, 32'h00060000);
    check("repulse_latency", 32'(lat), 32'd6);
    rv_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.result_valid) rv_cnt++;
    end
    check("repulse_extra_valid", 32'(rv_cnt), 32'd0);
    check("repulse_idle", 32'(bus.busy), 32'h0);

    // Back-to-back: second start lands on the result_valid cycle
    run_cmd(10'd200, 10'd3, 32'h0, 1'b0, 1'b0, lat, en_cnt, rd_cnt, res);
    check("b2b_first", res, 32'h00060000);
    run_cmd(10'd200, 10'd3, 32'h00010000, 1'b0, 1'b0, lat, en_cnt, rd_cnt, res);
    check("b2b_second_latency", 32'(lat), 32'd6);
    check("b2b_second_result", res, 32'h00070000);

    // Abort N=8 during FEED
    for (int i = 300; i < 308; i++) wmem[i] = 32'h00010000;
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 10'd300; bus.num_inputs = 10'd8;
    bus.bias = 32'h0; bus.relu_en = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_in_feed", {30'h0, bus.n_en, bus.mem_rd}, 32'h3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_result", bus.result, 32'h0);
    check("abort_ctrl", {28'h0, bus.result_valid, bus.mem_rd, bus.n_clear, bus.n_en}, 32'h0);
    check("abort_addr", {12'h0, bus.data_addr, bus.w_addr}, 32'h0);
    check("abort_ops", bus.n_data | bus.n_weight, 32'h0);
    rv_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.result_valid) rv_cnt++;
    end
    check("abort_no_valid", 32'(rv_cnt), 32'd0);
    // N=1 after abort: 3.0 * 0.5 + 1.0 = 2.5
    dmem[0] = 32'h00030000; wmem[400] = 32'h00008000;
    run_cmd(10'd400, 10'd1, 32'h00010000, 1'b0, 1'b0, lat, en_cnt, rd_cnt, res);
    check("post_abort_result", res, 32'h00028000);
    check("post_abort_latency", 32'(lat), 32'd4);
    dmem[0] = 32'h00010000;

    // Weight address wrap at the top of the 10-bit space
    wmem[1022] = 32'h00010000; wmem[1023] = 32'h00010000;
    wmem[0] = 32'h00010000; wmem[1] = 32'h00010000;
    repeat (2) @(negedge clk);
    run_cmd(10'd1022, 10'd4, 32'h0, 1'b0, 1'b0, lat, en_cnt, rd_cnt, res);
    check("wrap_result", res, 32'h00040000);
    check("wrap_w_addr0", 32'(wa_log[0]), 32'd1022);
    check("wrap_w_addr1", 32'(wa_log[1]), 32'd1023);
    check("wrap_w_addr2", 32'(wa_log[2]), 32'd0);
    check("wrap_w_addr3", 32'(wa_log[3]), 32'd1);
    for (int i = 0; i < 4; i++) check("wrap_data_addr", 32'(da_log[i]), 32'(i));

    check("operand_gating", 32'(gate_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
